// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Resolves branches, runs multi-cycle loads/stores
// against an internal word RAM, and drives the MEM/WB register.
//
// Parameters:
//   DEPTH        data RAM words (power of two)
//   ADDR_BITS    log2(DEPTH)
//   MEM_LATENCY  cycles per load/store (>= 1)
//
// Ports:
//   CLK, RESET (synchronous, active-high)
//   in_*         registered EX/MEM fields
//   PCSrc        branch taken (combinational)
//   PCBranchOut  branch target passthrough (combinational)
//   Stall        freezes PC, IF/ID, ID/EX, EX/MEM during a multi-cycle access
//   RegWrite, MemtoReg, ReadData, ALUOut, WriteReg   MEM/WB register
//   MisalignErr  sticky misaligned-access flag
//
// Optional build macro MEM_STAGE_MISALIGN_TRAP_EN: misaligned memops are
// suppressed at completion and set MisalignErr. Without it, address bits
// [1:0] are ignored and MisalignErr is tied low.
module mem_stage #(
  parameter int DEPTH       = 256,
  parameter int ADDR_BITS   = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        in_RegWrite,
  input  logic        in_MemtoReg,
  input  logic        in_MemWrite,
  input  logic        in_Branch,
  input  logic        in_zero,
  input  logic [31:0] in_ALUOut,
  input  logic [31:0] in_WriteData,
  input  logic [4:0]  in_WriteReg,
  input  logic [31:0] in_PCBranch,
  output logic        PCSrc,
  output logic [31:0] PCBranchOut,
  output logic        Stall,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic [31:0] ReadData,
  output logic [31:0] ALUOut,
  output logic [4:0]  WriteReg,
  output logic        MisalignErr
);

  // A latency of 1 never uses the counter; keep it one bit wide then.
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nx;
  logic            stall_c;
  logic            bubble;
  logic            done;
  logic            memop;
  logic            mis;
  logic            mis_done;
  logic [ADDR_BITS-1:0] idx;

  logic [31:0] mem [DEPTH];

  assign memop       = in_MemtoReg | in_MemWrite;
  assign idx         = in_ALUOut[ADDR_BITS+1:2];
  assign PCSrc       = in_Branch & in_zero;
  assign PCBranchOut = in_PCBranch;
  assign Stall       = stall_c & ~RESET;
  assign mis_done    = done & mis;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic err_q;

  assign mis         = memop & (in_ALUOut[1:0] != 2'b00);
  assign MisalignErr = err_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_q <= 1'b0;
    end else if (mis_done) begin
      err_q <= 1'b1;
    end
  end
`else
  assign mis         = 1'b0;
  assign MisalignErr = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall_c  = 1'b0;
    bubble   = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (memop) begin
          if (MEM_LATENCY == 1) begin
            done = 1'b1;
          end else begin
            stall_c  = 1'b1;
            bubble   = 1'b1;
            cnt_nx   = CW'(MEM_LATENCY - 2);
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          stall_c = 1'b1;
          bubble  = 1'b1;
          cnt_nx  = cnt - 1'b1;
        end else begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      RegWrite <= 1'b0;
      MemtoReg <= 1'b0;
      ReadData <= '0;
      ALUOut   <= '0;
      WriteReg <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (bubble) begin
        RegWrite <= 1'b0;
        MemtoReg <= 1'b0;
        ReadData <= '0;
        ALUOut   <= '0;
        WriteReg <= '0;
      end else begin
        RegWrite <= in_RegWrite & ~mis_done;
        MemtoReg <= in_MemtoReg;
        ReadData <= (done & in_MemtoReg & ~mis) ? mem[idx] : '0;
        ALUOut   <= in_ALUOut;
        WriteReg <= in_WriteReg;
      end
    end
  end

  // No reset on the array; RESET only blocks a pending write.
  always_ff @(posedge CLK) begin
    if (!RESET && done && in_MemWrite && !mis) begin
      mem[idx] <= in_WriteData;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage.
// Expected MEM/WB records are queued on drive and popped on completion.
module tb_mem_stage;

  parameter int LAT = 2;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        in_RegWrite;
  logic        in_MemtoReg;
  logic        in_MemWrite;
  logic        in_Branch;
  logic        in_zero;
  logic [31:0] in_ALUOut;
  logic [31:0] in_WriteData;
  logic [4:0]  in_WriteReg;
  logic [31:0] in_PCBranch;
  logic        PCSrc;
  logic [31:0] PCBranchOut;
  logic        Stall;
  logic        RegWrite;
  logic        MemtoReg;
  logic [31:0] ReadData;
  logic [31:0] ALUOut;
  logic [4:0]  WriteReg;
  logic        MisalignErr;

  mem_stage #(
    .DEPTH(256),
    .ADDR_BITS(8),
    .MEM_LATENCY(LAT)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .in_RegWrite(in_RegWrite),
    .in_MemtoReg(in_MemtoReg),
    .in_MemWrite(in_MemWrite),
    .in_Branch(in_Branch),
    .in_zero(in_zero),
    .in_ALUOut(in_ALUOut),
    .in_WriteData(in_WriteData),
    .in_WriteReg(in_WriteReg),
    .in_PCBranch(in_PCBranch),
    .PCSrc(PCSrc),
    .PCBranchOut(PCBranchOut),
    .Stall(Stall),
    .RegWrite(RegWrite),
    .MemtoReg(MemtoReg),
    .ReadData(ReadData),
    .ALUOut(ALUOut),
    .WriteReg(WriteReg),
    .MisalignErr(MisalignErr)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [256];
  logic        exp_err = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    in_RegWrite  = 1'b0;
    in_MemtoReg  = 1'b0;
    in_MemWrite  = 1'b0;
    in_Branch    = 1'b0;
    in_zero      = 1'b0;
    in_ALUOut    = '0;
    in_WriteData = '0;
    in_WriteReg  = '0;
    in_PCBranch  = '0;
  endtask

  task automatic do_op(input logic ld, input logic st, input logic rw,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] wr);
    exp_t e;
    exp_t g;
    int   idx;
    logic mis;
    int   stalls;
    bit   done;
    @(negedge CLK);
    in_RegWrite  = rw;
    in_MemtoReg  = ld;
    in_MemWrite  = st;
    in_Branch    = 1'b0;
    in_zero      = 1'b0;
    in_ALUOut    = addr;
    in_WriteData = wd;
    in_WriteReg  = wr;
    idx = int'(addr[9:2]);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    mis = (addr[1:0] != 2'b00) & (ld | st);
`else
    mis = 1'b0;
`endif
    if (mis) exp_err = 1'b1;
    e.rw  = rw & ~mis;
    e.m2r = ld;
    e.rd  = (ld && !mis) ? model[idx] : 32'h0;
    e.alu = addr;
    e.wr  = wr;
    e.err = exp_err;
    if (st && !mis) model[idx] = wd;
    exp_q.push_back(e);
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (Stall) begin
        stalls++;
        @(posedge CLK);
        #1;
        check("bubble_ctl", {RegWrite, MemtoReg, WriteReg}, 32'h0);
        check("bubble_data", ReadData | ALUOut, 32'h0);
        @(negedge CLK);
      end else begin
        @(posedge CLK);
        #1;
        g = exp_q.pop_front();
        check("RegWrite", RegWrite, g.rw);
        check("MemtoReg", MemtoReg, g.m2r);
        check("ReadData", ReadData, g.rd);
        check("ALUOut", ALUOut, g.alu);
        check("WriteReg", WriteReg, g.wr);
        check("MisalignErr", MisalignErr, g.err);
        done = 1'b1;
      end
    end
    check("op_done", done, 1);
    check("stall_cycles", stalls, (ld | st) ? LAT - 1 : 0);
  endtask

  initial begin
    RESET        = 1'b1;
    in_RegWrite  = 1'b1;
    in_MemtoReg  = 1'b1;
    in_MemWrite  = 1'b1;
    in_Branch    = 1'b1;
    in_zero      = 1'b1;
    in_ALUOut    = 32'h0000_0044;
    in_WriteData = 32'hFFFF_0000;
    in_WriteReg  = 5'd17;
    in_PCBranch  = 32'h0000_1000;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ctl", {RegWrite, MemtoReg, WriteReg, MisalignErr}, 32'h0);
    check("rst_data", ReadData | ALUOut, 32'h0);
    check("rst_stall", Stall, 0);
    check("rst_pcsrc", PCSrc, 1);
    in_zero = 1'b0;
    #1;
    check("rst_pcsrc0", PCSrc, 0);
    @(negedge CLK);
    RESET = 1'b0;
    idle_in();

    // Branch resolution
    @(negedge CLK);
    in_Branch   = 1'b1;
    in_zero     = 1'b1;
    in_PCBranch = 32'h40;
    #1;
    check("br_pcsrc", PCSrc, 1);
    check("br_target", PCBranchOut, 32'h40);
    check("br_stall", Stall, 0);
    in_zero = 1'b0;
    #1;
    check("br_nottaken", PCSrc, 0);
    idle_in();

    // ALU passthrough, then store/load
    do_op(1'b0, 1'b0, 1'b1, 32'h77, 32'h0, 5'd12);
    do_op(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd0);
    do_op(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd5);

    // Address wrap
    do_op(1'b0, 1'b1, 1'b0, 32'h400, 32'h1234, 5'd0);
    do_op(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 5'd7);

    // Load with store returns old word
    do_op(1'b1, 1'b1, 1'b1, 32'h0, 32'hCAFE_0001, 5'd8);
    do_op(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 5'd8);

    // Reset during an in-flight store
    do_op(1'b0, 1'b1, 1'b0, 32'h20, 32'hAAAA_0000, 5'd0);
    @(negedge CLK);
    in_MemWrite  = 1'b1;
    in_ALUOut    = 32'h20;
    in_WriteData = 32'h5555;
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("abort_ctl", {RegWrite, MemtoReg, WriteReg, MisalignErr}, 32'h0);
    check("abort_data", ReadData | ALUOut, 32'h0);
    check("abort_stall", Stall, 0);
    if (LAT == 1) model[8] = 32'h5555;
    exp_err = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    idle_in();
    do_op(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 5'd6);

    // Misaligned accesses and sticky error
    do_op(1'b0, 1'b1, 1'b0, 32'h13, 32'h0000_0BAD, 5'd0);
    do_op(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd9);
    do_op(1'b1, 1'b0, 1'b1, 32'h11, 32'h0, 5'd3);
    do_op(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 5'd4);
    do_op(1'b0, 1'b0, 1'b1, 32'h5A, 32'h0, 5'd2);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
